// File: rtl/ariane_regfile_pkg.sv
// ----------------------------------------------------------------------------
// ariane_regfile_pkg
// Shared types and helpers for the live-value-table register file.
//   state_e  : initialisation / normal-operation state of the array.
//   lvtWidth : number of bits needed to name one write bank in the LVT
//              (at least 1 so a single-port build still has a real entry).
// ----------------------------------------------------------------------------
package ariane_regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // An LVT entry names the bank holding the newest value of a word.
    // One write port still gets a one-bit entry so the table is never empty.
    function automatic int unsigned lvtWidth(input int unsigned nrWritePorts);
        if (nrWritePorts <= 1) begin
            return 1;
        end
        return $clog2(nrWritePorts);
    endfunction

endpackage

// File: rtl/regfile_bank.sv
// ----------------------------------------------------------------------------
// regfile_bank
// One memory bank of the LVT register file: a single synchronous write port
// and NR_READ_PORTS combinational read ports. The storage has no reset; the
// owning register file is responsible for zeroing it after reset.
// Ports:
//   clk_i    : clock, write happens on rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : flattened read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata_o  : flattened read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
// ----------------------------------------------------------------------------
module regfile_bank
    import ariane_regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter int unsigned NR_READ_PORTS = 2
) (
    input  logic                                  clk_i,
    input  logic                                  we_i,
    input  logic [ADDR_WIDTH-1:0]                 waddr_i,
    input  logic [DATA_WIDTH-1:0]                 wdata_i,
    input  logic [NR_READ_PORTS*ADDR_WIDTH-1:0]   raddr_i,
    output logic [NR_READ_PORTS*DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

    // Storage array: plain synchronous write, deliberately without reset so
    // it maps onto RAM-like structures.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Every read port looks up its word combinationally.
    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < NR_READ_PORTS; k++) begin
            rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

endmodule

// File: rtl/ariane_regfile_lvt.sv
// ----------------------------------------------------------------------------
// ariane_regfile_lvt
// Multi-ported register file built from one bank per write port plus a
// live-value table (LVT) that records which bank holds the newest copy of
// each word. After reset (or a clear request) the array walks through every
// address, zeroing bank 0 and pointing the LVT at bank 0, before it reports
// ready.
// Ports:
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset
//   clear_i  : request to re-zero the whole array
//   ready_o  : high once initialisation is complete
//   raddr_i  : flattened read addresses   (NR_READ_PORTS x ADDR_WIDTH)
//   rdata_o  : flattened read data        (NR_READ_PORTS x DATA_WIDTH)
//   waddr_i  : flattened write addresses  (NR_WRITE_PORTS x ADDR_WIDTH)
//   wdata_i  : flattened write data       (NR_WRITE_PORTS x DATA_WIDTH)
//   we_i     : per-port write enables
// ----------------------------------------------------------------------------
module ariane_regfile_lvt
    import ariane_regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned NR_READ_PORTS  = 2,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter bit          ZERO_REG_ZERO  = 1'b0,
    parameter bit          BYPASS_EN      = 1'b0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   clear_i,
    output logic                                   ready_o,
    input  logic [NR_READ_PORTS*ADDR_WIDTH-1:0]    raddr_i,
    output logic [NR_READ_PORTS*DATA_WIDTH-1:0]    rdata_o,
    input  logic [NR_WRITE_PORTS*ADDR_WIDTH-1:0]   waddr_i,
    input  logic [NR_WRITE_PORTS*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NR_WRITE_PORTS-1:0]              we_i
);

    localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int unsigned LVT_W     = lvtWidth(NR_WRITE_PORTS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LVT_W-1:0]        lvt_q [NUM_WORDS];
    logic [LVT_W-1:0]        lvt_d [NUM_WORDS];
    logic                    ready_q;

    logic                                 bankWe    [NR_WRITE_PORTS];
    logic [ADDR_WIDTH-1:0]                bankWaddr [NR_WRITE_PORTS];
    logic [DATA_WIDTH-1:0]                bankWdata [NR_WRITE_PORTS];
    logic [NR_READ_PORTS*DATA_WIDTH-1:0]  bankRdata [NR_WRITE_PORTS];
    logic [ADDR_WIDTH-1:0]                readAddr  [NR_READ_PORTS];
    logic [DATA_WIDTH-1:0]                readWord  [NR_READ_PORTS];

    // Split the flattened read address bus into per-port addresses and
    // reassemble the per-port read words onto the output bus.
    for (genvar k = 0; k < NR_READ_PORTS; k++) begin : gen_read_ports
        assign readAddr[k] = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = readWord[k];
    end

    // One bank per write port. Bank 0's write port is shared with the
    // initialisation sweep; the mux lives in the next-state logic below.
    for (genvar j = 0; j < NR_WRITE_PORTS; j++) begin : gen_banks
        regfile_bank #(
            .DATA_WIDTH    (DATA_WIDTH),
            .ADDR_WIDTH    (ADDR_WIDTH),
            .NR_READ_PORTS (NR_READ_PORTS)
        ) u_bank (
            .clk_i   (clk_i),
            .we_i    (bankWe[j]),
            .waddr_i (bankWaddr[j]),
            .wdata_i (bankWdata[j]),
            .raddr_i (raddr_i),
            .rdata_o (bankRdata[j])
        );
    end

    // Next-state logic. In INIT the counter sweeps every address, writing
    // zero into bank 0 and pointing the LVT at bank 0; user writes are
    // ignored. A clear request (in either state) restarts the sweep and
    // throws away any write presented in the same cycle. In RUN, ports are
    // scanned in ascending order so the highest-numbered port wins the LVT
    // entry when several ports hit the same address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvt_d   = lvt_q;
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
            bankWe[j]    = 1'b0;
            bankWaddr[j] = waddr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
            bankWdata[j] = wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
        end

        case (state_q)
            INIT: begin
                bankWe[0]     = 1'b1;
                bankWaddr[0]  = cnt_q;
                bankWdata[0]  = '0;
                lvt_d[cnt_q]  = '0;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            RUN: begin
                if (clear_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else begin
                    for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                        if (we_i[j]) begin
                            bankWe[j] = 1'b1;
                            lvt_d[waddr_i[j*ADDR_WIDTH +: ADDR_WIDTH]] = LVT_W'(j);
                        end
                    end
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State, sweep counter, LVT and the registered ready flag. Reset forces
    // a fresh initialisation sweep; the banks themselves are not reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                lvt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == RUN);
            lvt_q   <= lvt_d;
        end
    end

    assign ready_o = ready_q;

    // Read path: pick the bank the LVT names, then let a same-cycle write
    // (highest matching port) override it when forwarding is enabled. The
    // zero register and the not-yet-initialised array both force zero and
    // take precedence over everything else.
    always_comb begin
        for (int k = 0; k < NR_READ_PORTS; k++) begin
            readWord[k] = '0;
            for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                if (lvt_q[readAddr[k]] == LVT_W'(j)) begin
                    readWord[k] = bankRdata[j][k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (BYPASS_EN) begin
                for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                    if (we_i[j] && !clear_i &&
                        (waddr_i[j*ADDR_WIDTH +: ADDR_WIDTH] == readAddr[k])) begin
                        readWord[k] = wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            if (ZERO_REG_ZERO && (readAddr[k] == '0)) begin
                readWord[k] = '0;
            end
            if (state_q != RUN) begin
                readWord[k] = '0;
            end
        end
    end

endmodule

// File: doc/ariane_regfile_lvt.md
ARIANE_REGFILE_LVT -- requirements
Module: ariane_regfile_lvt

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning NUM_WORDS = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NR_READ_PORTS, default 2, meaning async read port count (>=1).
REQ-004 SHALL have parameter NR_WRITE_PORTS, default 2, meaning sync write port count (>=1).
REQ-005 SHALL have parameter ZERO_REG_ZERO, default 0, meaning address 0 always reads zero.
REQ-006 SHALL have parameter BYPASS_EN, default 0, meaning same-cycle write-to-read forwarding.
REQ-007 SHALL have one clock and an asynchronous, active-high reset.
REQ-008 clk_i  input  1  clock; all state updates on rising edge.
REQ-009 rst_i  input  1  asynchronous active-high reset.
REQ-010 clear_i  input  1  request to zero the whole array.
REQ-011 ready_o  output  1  array initialised; reads and writes valid.
REQ-012 raddr_i  input  NR_READ_PORTS x ADDR_WIDTH  read addresses.
REQ-013 rdata_o  output  NR_READ_PORTS x DATA_WIDTH  read data, combinational from raddr_i.
REQ-014 waddr_i  input  NR_WRITE_PORTS x ADDR_WIDTH  write addresses.
REQ-015 wdata_i  input  NR_WRITE_PORTS x DATA_WIDTH  write data.
REQ-016 we_i  input  NR_WRITE_PORTS  per-port write enables.

Function
REQ-017 SHALL hold one memory bank per write port; port j writes only bank j; banks have no reset.
REQ-018 SHALL keep a live-value table (LVT) of NUM_WORDS entries, each clog2(NR_WRITE_PORTS) bits (min 1), recording the bank holding the newest value.
REQ-019 Read k SHALL return bank[LVT[raddr_i[k]]][raddr_i[k]], latency 0.
REQ-020 Simultaneous writes to one address: all banks written, LVT takes highest port index.
REQ-021 BYPASS_EN=1, RUN, raddr_i[k] matches an enabled waddr_i: rdata_o[k] SHALL equal wdata_i of highest matching port in that cycle.
REQ-022 ZERO_REG_ZERO=1: raddr_i[k]==0 SHALL read 0, overriding bypass; writes to 0 still stored.
REQ-023 FSM states INIT, RUN; INIT: each edge writes 0 to bank 0 word cnt, sets LVT[cnt]=0, cnt++.
REQ-024 INIT -> RUN on the edge where cnt==NUM_WORDS-1; INIT lasts exactly NUM_WORDS cycles.
REQ-025 RUN -> INIT with cnt=0 on edge where clear_i=1; we_i in that cycle SHALL be discarded.
REQ-026 clear_i=1 during INIT SHALL restart cnt at 0.
REQ-027 In INIT, we_i SHALL be ignored and rdata_o SHALL be 0.
REQ-028 ready_o SHALL be registered, high exactly when state is RUN.
REQ-029 Write-port wrap: cnt is ADDR_WIDTH+0 bits and never exceeds NUM_WORDS-1.

Reset
REQ-030 rst_i high SHALL asynchronously force state=INIT, cnt=0, LVT all 0, ready_o=0, rdata_o=0.
REQ-031 rst_i mid-INIT or mid-RUN SHALL abort and restart full initialisation after release.

Structure
REQ-032 Package ariane_regfile_pkg SHALL hold the state enum (INIT, RUN) and LVT-width helper constant function.
REQ-033 Sub-module regfile_bank SHALL implement one sync-write, NR_READ_PORTS async-read bank, instanced NR_WRITE_PORTS times.
REQ-034 Bank 0 write port SHALL be muxed between init-clear and we_i[0]; no extra write port.

Verification
REQ-035 Reset release, idle -> ready_o 0 for 32 cycles (ADDR_WIDTH=5), 1 on 32nd edge; all reads 0.
REQ-036 Port0 writes 0xA5 to x7, next cycle port1 writes 0x5A to x7 -> read x7 = 0x5A; then port0 writes 0x11 -> 0x11.
REQ-037 Ports 0 and 1 write 0x1, 0x2 to x3 same cycle -> x3 reads 0x2 on both read ports.
REQ-038 BYPASS_EN=1, port1 writes 0xCAFE to x9 while reading x9 -> rdata_o=0xCAFE same cycle; BYPASS_EN=0 -> old value.
REQ-039 After writing x1..x31, pulse clear_i with we_i[0]=1 to x4 -> ready_o low 32 cycles, then every address reads 0.
REQ-040 ZERO_REG_ZERO=1, write 0xFF to x0 -> x0 reads 0; rst_i asserted mid-INIT at cnt=10 -> INIT restarts, 32 cycles.
